// File: rtl/ysyx_23060240_csr_pkg.sv
// Shared definitions for the CSR sequencer: op encodings, CSR addresses, mcause codes, FSM states.
// Consumed by ysyx_23060240_csr_seq (feature macro CSR_SEQ_ILLEGAL_CHK_EN) and ysyx_23060240_csr_alu.
package ysyx_23060240_csr_pkg;

  localparam logic [2:0] OpCsrrw = 3'd0;
  localparam logic [2:0] OpCsrrs = 3'd1;
  localparam logic [2:0] OpCsrrc = 3'd2;
  localparam logic [2:0] OpEcall = 3'd3;
  localparam logic [2:0] OpMret  = 3'd4;

  localparam logic [11:0] CsrMstatus = 12'h300;
  localparam logic [11:0] CsrMtvec   = 12'h305;
  localparam logic [11:0] CsrMepc    = 12'h341;
  localparam logic [11:0] CsrMcause  = 12'h342;

  localparam logic [31:0] McauseEcallM  = 32'hb;
  localparam logic [31:0] McauseIllegal = 32'h2;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StWr,
    StEcMepc,
    StEcCause,
    StRdVec,
    StRdEpc,
    StResp
  } seq_state_e;

  function automatic logic csr_addr_known(input logic [11:0] addr);
    return (addr == CsrMstatus) || (addr == CsrMtvec) || (addr == CsrMepc) || (addr == CsrMcause);
  endfunction

endpackage

// File: rtl/ysyx_23060240_csr_seq_if.sv
// EXU request, CSR-file port and IFU response signals of the CSR sequencer.
// master = sequencer side, slave = EXU / CSR file / IFU side.
interface ysyx_23060240_csr_seq_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_op;
  logic [11:0]     req_csr;
  logic [XLEN-1:0] req_src;
  logic            req_src_x0;
  logic [XLEN-1:0] req_pc;

  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic            csr_wen;
  logic            csr_ren;
  logic [XLEN-1:0] csr_rdata;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_rd_data;
  logic            rsp_redirect;
  logic [XLEN-1:0] rsp_pc;

  modport master (
    input  req_valid, req_op, req_csr, req_src, req_src_x0, req_pc,
    output req_ready,
    output csr_addr, csr_wdata, csr_wen, csr_ren,
    input  csr_rdata,
    output rsp_valid, rsp_rd_data, rsp_redirect, rsp_pc,
    input  rsp_ready
  );

  modport slave (
    output req_valid, req_op, req_csr, req_src, req_src_x0, req_pc,
    input  req_ready,
    input  csr_addr, csr_wdata, csr_wen, csr_ren,
    output csr_rdata,
    input  rsp_valid, rsp_rd_data, rsp_redirect, rsp_pc,
    output rsp_ready
  );
endinterface

// File: rtl/ysyx_23060240_csr_alu.sv
// Combinational CSR write-data generator: swap, set-bits or clear-bits of the old value.
module ysyx_23060240_csr_alu
  import ysyx_23060240_csr_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_old,
  input  logic [XLEN-1:0] i_src,
  output logic [XLEN-1:0] o_wdata
);

  always_comb begin
    o_wdata = i_src;
    case (i_op)
      OpCsrrs: o_wdata = i_old | i_src;
      OpCsrrc: o_wdata = i_old & ~i_src;
      default: o_wdata = i_src;
    endcase
  end

endmodule

// File: rtl/ysyx_23060240_csr_seq.sv
// CSR sequencer: turns one CSR-class op into a short series of CSR-file reads/writes.
// Optional CSR_SEQ_ILLEGAL_CHK_EN traps CSR ops to unknown addresses as illegal instructions.
module ysyx_23060240_csr_seq
  import ysyx_23060240_csr_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] MCAUSE_EC = XLEN'(McauseEcallM)
) (
  input logic                      clk,
  input logic                      rst_n,
  ysyx_23060240_csr_seq_if.master  bus
);

  seq_state_e      r_state;
  seq_state_e      w_state_d;
  logic [2:0]      r_op;
  logic [11:0]     r_csr;
  logic [XLEN-1:0] r_src;
  logic            r_src_x0;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_old;
  logic [XLEN-1:0] r_rsp_pc;
  logic            r_redirect;
  logic            w_accept;
  logic            w_redirect;
  logic [XLEN-1:0] w_alu_wdata;
  logic [XLEN-1:0] w_cause;
  logic            w_illegal;

`ifdef CSR_SEQ_ILLEGAL_CHK_EN
  logic r_illegal;

  assign w_illegal = ((bus.req_op == OpCsrrw) || (bus.req_op == OpCsrrs) ||
                      (bus.req_op == OpCsrrc)) && !csr_addr_known(bus.req_csr);
  assign w_cause   = r_illegal ? XLEN'(McauseIllegal) : MCAUSE_EC;
`else
  assign w_illegal = 1'b0;
  assign w_cause   = MCAUSE_EC;
`endif

  assign w_accept   = bus.req_valid && (r_state == StIdle);
  assign w_redirect = (bus.req_op == OpEcall) || (bus.req_op == OpMret) || w_illegal;

  ysyx_23060240_csr_alu #(
    .XLEN (XLEN)
  ) u_alu (
    .i_op    (r_op),
    .i_old   (r_old),
    .i_src   (r_src),
    .o_wdata (w_alu_wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_op       <= '0;
      r_csr      <= '0;
      r_src      <= '0;
      r_src_x0   <= 1'b0;
      r_pc       <= '0;
      r_old      <= '0;
      r_rsp_pc   <= '0;
      r_redirect <= 1'b0;
`ifdef CSR_SEQ_ILLEGAL_CHK_EN
      r_illegal  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_op       <= bus.req_op;
        r_csr      <= bus.req_csr;
        r_src      <= bus.req_src;
        r_src_x0   <= bus.req_src_x0;
        r_pc       <= bus.req_pc;
        r_old      <= '0;
        r_rsp_pc   <= '0;
        r_redirect <= w_redirect;
`ifdef CSR_SEQ_ILLEGAL_CHK_EN
        r_illegal  <= w_illegal;
`endif
      end
      if (r_state == StRd) r_old <= bus.csr_rdata;
      if ((r_state == StRdVec) || (r_state == StRdEpc)) r_rsp_pc <= bus.csr_rdata;
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle: begin
        if (bus.req_valid) begin
          case (bus.req_op)
            OpCsrrw, OpCsrrs, OpCsrrc: w_state_d = w_illegal ? StEcMepc : StRd;
            OpEcall:                   w_state_d = StEcMepc;
            OpMret:                    w_state_d = StRdEpc;
            default:                   w_state_d = StResp;
          endcase
        end
      end
      // Set/clear with rs1 == x0 is a pure read.
      StRd:      w_state_d = ((r_op != OpCsrrw) && r_src_x0) ? StResp : StWr;
      StWr:      w_state_d = StResp;
      StEcMepc:  w_state_d = StEcCause;
      StEcCause: w_state_d = StRdVec;
      StRdVec:   w_state_d = StResp;
      StRdEpc:   w_state_d = StResp;
      StResp:    if (bus.rsp_ready) w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.csr_addr  = '0;
    bus.csr_wdata = '0;
    bus.csr_wen   = 1'b0;
    bus.csr_ren   = 1'b0;
    case (r_state)
      StRd: begin
        bus.csr_ren  = 1'b1;
        bus.csr_addr = r_csr;
      end
      StWr: begin
        bus.csr_wen   = 1'b1;
        bus.csr_addr  = r_csr;
        bus.csr_wdata = w_alu_wdata;
      end
      StEcMepc: begin
        bus.csr_wen   = 1'b1;
        bus.csr_addr  = CsrMepc;
        bus.csr_wdata = r_pc;
      end
      StEcCause: begin
        bus.csr_wen   = 1'b1;
        bus.csr_addr  = CsrMcause;
        bus.csr_wdata = w_cause;
      end
      StRdVec: begin
        bus.csr_ren  = 1'b1;
        bus.csr_addr = CsrMtvec;
      end
      StRdEpc: begin
        bus.csr_ren  = 1'b1;
        bus.csr_addr = CsrMepc;
      end
      default: ;
    endcase
  end

  assign bus.req_ready    = (r_state == StIdle);
  assign bus.rsp_valid    = (r_state == StResp);
  assign bus.rsp_rd_data  = bus.rsp_valid ? r_old : '0;
  assign bus.rsp_redirect = bus.rsp_valid && r_redirect;
  assign bus.rsp_pc       = bus.rsp_valid ? r_rsp_pc : '0;

endmodule

// File: tb/tb_ysyx_23060240_csr_seq.sv
// Directed bench for the CSR sequencer with a four-register CSR-file model.
module tb_ysyx_23060240_csr_seq;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  ysyx_23060240_csr_seq_if #(.XLEN(32)) bus ();

  ysyx_23060240_csr_seq #(
    .XLEN      (32),
    .MCAUSE_EC (32'hb)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] m_mstatus = '0;
  logic [31:0] m_mtvec   = '0;
  logic [31:0] m_mepc    = '0;
  logic [31:0] m_mcause  = '0;
  int          wen_cnt   = 0;
  int          both_cnt  = 0;
  int          cyc       = 0;
  int          acc_cyc   = 0;
  int          wen_cyc   = 0;
  logic [11:0] wen_addr  = '0;
  logic [31:0] wen_data  = '0;

  always_comb begin
    bus.csr_rdata = '0;
    case (bus.csr_addr)
      12'h300: bus.csr_rdata = m_mstatus;
      12'h305: bus.csr_rdata = m_mtvec;
      12'h341: bus.csr_rdata = m_mepc;
      12'h342: bus.csr_rdata = m_mcause;
      default: bus.csr_rdata = '0;
    endcase
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.req_valid && bus.req_ready) acc_cyc <= cyc;
    if (bus.csr_wen && bus.csr_ren) both_cnt <= both_cnt + 1;
    if (bus.csr_wen) begin
      wen_cnt  <= wen_cnt + 1;
      wen_cyc  <= cyc;
      wen_addr <= bus.csr_addr;
      wen_data <= bus.csr_wdata;
      case (bus.csr_addr)
        12'h300: m_mstatus <= bus.csr_wdata;
        12'h305: m_mtvec   <= bus.csr_wdata;
        12'h341: m_mepc    <= bus.csr_wdata;
        12'h342: m_mcause  <= bus.csr_wdata;
        default: ;
      endcase
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where rsp_valid is first seen.
  task automatic run_op(input logic [2:0] op, input logic [11:0] csr, input logic [31:0] src,
                        input logic x0, input logic [31:0] pc, output int lat);
    check_eq("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_op     = op;
    bus.req_csr    = csr;
    bus.req_src    = src;
    bus.req_src_x0 = x0;
    bus.req_pc     = pc;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.rsp_valid && lat < 20);
  endtask

  task automatic take_rsp();
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    @(negedge clk);
    check_eq("back_idle", 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int lat;
  int w0;

  initial begin
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_csr = '0; bus.req_src = '0;
    bus.req_src_x0 = 1'b0; bus.req_pc = '0; bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check_eq("rst_wen_ren", {30'd0, bus.csr_wen, bus.csr_ren}, 32'd0);
    check_eq("rst_addr", 32'(bus.csr_addr), 32'd0);
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: CSRRW mtvec
    w0 = wen_cnt;
    run_op(3'd0, 12'h305, 32'h8000_0100, 1'b0, 32'h0, lat);
    check_eq("t1_latency", 32'(lat), 32'd3);
    check_eq("t1_wen_cycle", 32'(wen_cyc - acc_cyc), 32'd2);
    check_eq("t1_wen_count", 32'(wen_cnt - w0), 32'd1);
    check_eq("t1_wen_addr", 32'(wen_addr), 32'h305);
    check_eq("t1_wen_data", wen_data, 32'h8000_0100);
    check_eq("t1_rd_data", bus.rsp_rd_data, 32'h0);
    check_eq("t1_redirect", 32'(bus.rsp_redirect), 32'd0);
    take_rsp();

    // 2: CSRRS then CSRRC on mstatus
    run_op(3'd1, 12'h300, 32'h1800, 1'b0, 32'h0, lat);
    check_eq("t2_rs_rd", bus.rsp_rd_data, 32'h0);
    take_rsp();
    run_op(3'd2, 12'h300, 32'h0800, 1'b0, 32'h0, lat);
    check_eq("t2_rc_rd", bus.rsp_rd_data, 32'h1800);
    take_rsp();
    check_eq("t2_mstatus", m_mstatus, 32'h1000);

    // 3: CSRRS with rs1 = x0 is read-only
    w0 = wen_cnt;
    run_op(3'd1, 12'h342, 32'hffff_ffff, 1'b1, 32'h0, lat);
    check_eq("t3_latency", 32'(lat), 32'd2);
    check_eq("t3_no_wen", 32'(wen_cnt - w0), 32'd0);
    check_eq("t3_rd_data", bus.rsp_rd_data, 32'h0);
    take_rsp();

    // 4: ECALL
    w0 = wen_cnt;
    run_op(3'd3, 12'h000, 32'h0, 1'b0, 32'h8000_0040, lat);
    check_eq("t4_latency", 32'(lat), 32'd4);
    check_eq("t4_mepc", m_mepc, 32'h8000_0040);
    check_eq("t4_mcause", m_mcause, 32'hb);
    check_eq("t4_wen_count", 32'(wen_cnt - w0), 32'd2);
    check_eq("t4_rsp_pc", bus.rsp_pc, 32'h8000_0100);
    check_eq("t4_redirect", 32'(bus.rsp_redirect), 32'd1);
    check_eq("t4_rd_data", bus.rsp_rd_data, 32'h0);
    take_rsp();

    // 5: MRET with consumer back-pressure; a pending request must wait for IDLE
    w0 = wen_cnt;
    run_op(3'd4, 12'h000, 32'h0, 1'b0, 32'h0, lat);
    check_eq("t5_latency", 32'(lat), 32'd2);
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("t5_hold_valid", 32'(bus.rsp_valid), 32'd1);
      check_eq("t5_hold_pc", bus.rsp_pc, 32'h8000_0040);
      check_eq("t5_hold_redirect", 32'(bus.rsp_redirect), 32'd1);
      check_eq("t5_hold_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
    check_eq("t5_no_same_cycle_accept", 32'(bus.req_ready), 32'd1);
    check_eq("t5_rsp_dropped", 32'(bus.rsp_valid), 32'd0);
    check_eq("t5_no_wen", 32'(wen_cnt - w0), 32'd0);
    check_eq("t5_mstatus", m_mstatus, 32'h1000);
    @(negedge clk);

    // Reserved op
    w0 = wen_cnt;
    run_op(3'd6, 12'h300, 32'h1234, 1'b0, 32'h0, lat);
    check_eq("rsv_latency", 32'(lat), 32'd1);
    check_eq("rsv_rd_data", bus.rsp_rd_data, 32'h0);
    check_eq("rsv_redirect", 32'(bus.rsp_redirect), 32'd0);
    check_eq("rsv_no_wen", 32'(wen_cnt - w0), 32'd0);
    take_rsp();

    // 6: reset while the mcause write is on the bus
    run_op(3'd0, 12'h342, 32'h5, 1'b0, 32'h0, lat);
    check_eq("t6_prev_mcause", bus.rsp_rd_data, 32'hb);
    take_rsp();
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd3;
    bus.req_pc    = 32'h8000_0080;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("t6_in_cause_addr", 32'(bus.csr_addr), 32'h342);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_wen", 32'(bus.csr_wen), 32'd0);
    check_eq("t6_rst_ren", 32'(bus.csr_ren), 32'd0);
    check_eq("t6_rst_addr", 32'(bus.csr_addr), 32'd0);
    check_eq("t6_rst_wdata", bus.csr_wdata, 32'd0);
    check_eq("t6_rst_rsp", {29'd0, bus.rsp_valid, bus.rsp_redirect, |bus.rsp_pc}, 32'd0);
    check_eq("t6_rst_req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check_eq("t6_mcause_kept", m_mcause, 32'h5);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("wen_ren_overlap", 32'(both_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
